// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// States, header length and bytes-per-word used by loader and assembler.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        DONE,
        ERROR
    } state_t;

    localparam int HDR_BYTES      = 4;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_byte_assembler.sv
// Collects four little-endian bytes into one 32-bit word.
// word_valid_o fires on the cycle the fourth byte is accepted.
module imem_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q;
    logic [31:0] shift_q;

    assign word_valid_o = byte_valid_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_o       = {byte_i, shift_q[31:8]};

    // Shift bytes in from the top so the oldest byte ends up in [7:0].
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {byte_i, shift_q[31:8]};
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed image into instruction memory.
// Holds the core in reset until the final word has been written.
module imem_boot_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH_WORDS  = 1024,
    parameter int ADDR_W       = $clog2(DEPTH_WORDS),
    parameter int BYTE_TIMEOUT = 100000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              core_reset_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    localparam int TMO_W = $clog2(BYTE_TIMEOUT + 1);

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       len_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              accept;
    logic              start_ok;
    logic              tmo_hit;
    logic              hdr_bad;
    logic              last_word;
    logic              word_valid;
    logic [31:0]       word;

    assign rx_ready_o = (state_q == HDR) || (state_q == DATA);
    assign busy_o     = rx_ready_o;
    assign done_o     = (state_q == DONE);
    assign error_o    = (state_q == ERROR);
    assign accept     = rx_valid_i && rx_ready_o;
    assign start_ok   = start_i && !busy_o;
    assign tmo_hit    = !accept && (tmo_q == TMO_W'(BYTE_TIMEOUT - 1));
    assign hdr_bad    = (word == 32'd0) || (word > 32'(DEPTH_WORDS));
    assign last_word  = (32'(words_loaded_o) + 32'd1) == len_q;

    assign core_reset_o = reset_i || busy_o || error_o || mem_we_o;

    imem_byte_assembler u_asm (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .clear_i      (start_ok),
        .byte_valid_i (accept),
        .byte_i       (rx_data_i),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state: header check, last-word detection and byte timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR: begin
                if (word_valid)   state_d = hdr_bad ? ERROR : DATA;
                else if (tmo_hit) state_d = ERROR;
            end
            DATA: begin
                if (word_valid && last_word) state_d = DONE;
                else if (tmo_hit)            state_d = ERROR;
            end
            default: begin
                if (start_i) state_d = HDR;
            end
        endcase
    end

    // Datapath: length capture, memory write pulse, counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_we_o       <= 1'b0;
            mem_waddr_o    <= '0;
            mem_wdata_o    <= '0;
            words_loaded_o <= '0;
            len_q          <= '0;
            tmo_q          <= '0;
        end else begin
            mem_we_o <= 1'b0;
            if (start_ok) begin
                words_loaded_o <= '0;
                len_q          <= '0;
                tmo_q          <= '0;
            end
            if (busy_o) begin
                tmo_q <= accept ? '0 : tmo_q + TMO_W'(1);
            end
            if (state_q == HDR && word_valid) begin
                len_q <= word;
            end
            if (state_q == DATA && word_valid) begin
                mem_we_o       <= 1'b1;
                mem_waddr_o    <= words_loaded_o[ADDR_W-1:0];
                mem_wdata_o    <= word;
                words_loaded_o <= words_loaded_o + (ADDR_W+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomised bench for imem_boot_loader against an image-level model.
// Expected writes are simply word i of the image at index i.
module tb_imem_boot_loader;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          reset_i;
    logic          start_i;
    logic [7:0]    rx_data_i;
    logic          rx_valid_i;
    logic          rx_ready_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_waddr_o;
    logic [31:0]   mem_wdata_o;
    logic          core_reset_o;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [AW:0]   words_loaded_o;

    int errors = 0;
    int checks = 0;

    logic [31:0]   img [0:7];
    logic [AW-1:0] wa_q [$];
    logic [31:0]   wd_q [$];

    imem_boot_loader #(
        .DEPTH_WORDS  (DEPTH),
        .BYTE_TIMEOUT (TMO)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .rx_data_i      (rx_data_i),
        .rx_valid_i     (rx_valid_i),
        .rx_ready_o     (rx_ready_o),
        .mem_we_o       (mem_we_o),
        .mem_waddr_o    (mem_waddr_o),
        .mem_wdata_o    (mem_wdata_o),
        .core_reset_o   (core_reset_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .words_loaded_o (words_loaded_o)
    );

    always #5 clk = ~clk;

    // Record every memory write as it appears.
    always @(negedge clk) begin
        if (mem_we_o) begin
            wa_q.push_back(mem_waddr_o);
            wd_q.push_back(mem_wdata_o);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int pct);
        int gap = 0;
        bit acc = 1'b0;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            rx_data_i  = b;
            rx_valid_i = ($urandom_range(0, 99) < pct) || (gap >= 8);
            gap        = rx_valid_i ? 0 : gap + 1;
            acc        = rx_valid_i && rx_ready_o;
            @(posedge clk);
        end
        @(negedge clk);
        rx_valid_i = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_byte: byte %02h not accepted, got ready=%0b want 1", b, rx_ready_o);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int pct);
        for (int i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)), pct);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_end(output int cyc);
        cyc = 0;
        while (!done_o && !error_o && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic test_reset();
        reset_i    = 1'b1;
        start_i    = 1'b0;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_ready_o, mem_we_o, busy_o, done_o, error_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %05b want 00000",
                     {rx_ready_o, mem_we_o, busy_o, done_o, error_o});
        end
        checks++;
        if (mem_waddr_o !== '0 || mem_wdata_o !== '0 || words_loaded_o !== '0) begin
            errors++;
            $display("FAIL reset_regs: got a=%0d d=%h n=%0d want 0 0 0",
                     mem_waddr_o, mem_wdata_o, words_loaded_o);
        end
        checks++;
        if (core_reset_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_core: got %0b want 1", core_reset_o);
        end
        reset_i    = 1'b0;
        rx_valid_i = 1'b1;
        @(negedge clk);
        checks++;
        if (core_reset_o !== 1'b0 || rx_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs: got core_reset=%0b ready=%0b want 0 0",
                     core_reset_o, rx_ready_o);
        end
        rx_valid_i = 1'b0;
    endtask

    task automatic test_basic();
        img[0] = 32'h00500093;
        img[1] = 32'h00A00113;
        clear_log();
        pulse_start();
        send_word(32'd2, 100);
        send_word(img[0], 100);
        send_word(img[1], 100);
        checks++;
        if (done_o !== 1'b1 || mem_we_o !== 1'b1 || mem_waddr_o !== 1) begin
            errors++;
            $display("FAIL basic_first_done: got done=%0b we=%0b a=%0d want 1 1 1",
                     done_o, mem_we_o, mem_waddr_o);
        end
        checks++;
        if (mem_wdata_o !== img[1] || words_loaded_o !== 2 || core_reset_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_last_write: got d=%h n=%0d cr=%0b want %h 2 1",
                     mem_wdata_o, words_loaded_o, core_reset_o, img[1]);
        end
        @(negedge clk);
        checks++;
        if (core_reset_o !== 1'b0 || mem_we_o !== 1'b0 || done_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: got cr=%0b we=%0b done=%0b want 0 0 1",
                     core_reset_o, mem_we_o, done_o);
        end
        checks++;
        if (wa_q.size() != 2) begin
            errors++;
            $display("FAIL basic_count: got %0d writes want 2", wa_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (wa_q[i] !== AW'(i) || wd_q[i] !== img[i]) begin
                    errors++;
                    $display("FAIL basic_write%0d: got a=%0d d=%h want a=%0d d=%h",
                             i, wa_q[i], wd_q[i], i, img[i]);
                end
            end
        end
    endtask

    task automatic test_random_valid();
        int cyc;
        int bad_ready = 0;
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        clear_log();
        pulse_start();
        send_word(32'd3, 30);
        for (int i = 0; i < 3; i++) send_word(img[i], 30);
        wait_end(cyc);
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || words_loaded_o !== 3) begin
            errors++;
            $display("FAIL rand_done: got done=%0b n=%0d want 1 3", done_o, words_loaded_o);
        end
        checks++;
        if (wa_q.size() != 3) begin
            errors++;
            $display("FAIL rand_count: got %0d writes want 3", wa_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa_q[i] !== AW'(i) || wd_q[i] !== img[i]) begin
                    errors++;
                    $display("FAIL rand_write%0d: got a=%0d d=%h want a=%0d d=%h",
                             i, wa_q[i], wd_q[i], i, img[i]);
                end
            end
        end
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            rx_valid_i = 1'($urandom_range(0, 1));
            rx_data_i  = 8'($urandom);
            if (rx_ready_o) bad_ready++;
        end
        rx_valid_i = 1'b0;
        checks++;
        if (bad_ready != 0 || words_loaded_o !== 3) begin
            errors++;
            $display("FAIL ready_after_done: got %0d ready cycles n=%0d want 0 3",
                     bad_ready, words_loaded_o);
        end
    endtask

    task automatic test_bad_header();
        logic [31:0] hdrs [0:1];
        hdrs[0] = 32'd0;
        hdrs[1] = 32'd1025;
        for (int h = 0; h < 2; h++) begin
            clear_log();
            pulse_start();
            send_word(hdrs[h], 100);
            checks++;
            if (error_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL bad_hdr_%0d: got err=%0b done=%0b busy=%0b want 1 0 0",
                         hdrs[h], error_o, done_o, busy_o);
            end
            repeat (5) @(negedge clk);
            checks++;
            if (core_reset_o !== 1'b1 || wa_q.size() != 0 || words_loaded_o !== 0) begin
                errors++;
                $display("FAIL bad_hdr_hold_%0d: got cr=%0b writes=%0d n=%0d want 1 0 0",
                         hdrs[h], core_reset_o, wa_q.size(), words_loaded_o);
            end
        end
    endtask

    task automatic test_timeout();
        int cyc = 0;
        img[0] = $urandom;
        img[1] = $urandom;
        clear_log();
        pulse_start();
        send_word(32'd2, 100);
        send_word(img[0], 100);
        send_byte(img[1][7:0], 100);
        send_byte(img[1][15:8], 100);
        while (!error_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != TMO) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d want %0d", cyc, TMO);
        end
        @(negedge clk);
        checks++;
        if (wa_q.size() != 1 || words_loaded_o !== 1 || core_reset_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_writes: got writes=%0d n=%0d cr=%0b want 1 1 1",
                     wa_q.size(), words_loaded_o, core_reset_o);
        end else begin
            checks++;
            if (wa_q[0] !== '0 || wd_q[0] !== img[0]) begin
                errors++;
                $display("FAIL timeout_word0: got a=%0d d=%h want 0 %h",
                         wa_q[0], wd_q[0], img[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        pulse_start();
        send_word(32'd3, 100);
        send_word(img[0], 100);
        send_byte(img[1][7:0], 100);
        reset_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({rx_ready_o, mem_we_o, busy_o, done_o, error_o} !== 5'b0 ||
            core_reset_o !== 1'b1) begin
            errors++;
            $display("FAIL midreset_flags: got %05b cr=%0b want 00000 1",
                     {rx_ready_o, mem_we_o, busy_o, done_o, error_o}, core_reset_o);
        end
        checks++;
        if (mem_waddr_o !== '0 || mem_wdata_o !== '0 || words_loaded_o !== '0) begin
            errors++;
            $display("FAIL midreset_regs: got a=%0d d=%h n=%0d want 0 0 0",
                     mem_waddr_o, mem_wdata_o, words_loaded_o);
        end
        reset_i = 1'b0;
        clear_log();
        pulse_start();
        send_word(32'd3, 100);
        for (int i = 0; i < 3; i++) send_word(img[i], 100);
        wait_end(cyc);
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || words_loaded_o !== 3 || wa_q.size() != 3) begin
            errors++;
            $display("FAIL midreset_reload: got done=%0b n=%0d writes=%0d want 1 3 3",
                     done_o, words_loaded_o, wa_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa_q[i] !== AW'(i) || wd_q[i] !== img[i]) begin
                    errors++;
                    $display("FAIL reload_write%0d: got a=%0d d=%h want a=%0d d=%h",
                             i, wa_q[i], wd_q[i], i, img[i]);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        clear_log();
        pulse_start();
        send_word(32'd3, 100);
        send_word(img[0], 100);
        send_byte(img[1][7:0], 100);
        pulse_start();
        send_byte(img[1][15:8], 100);
        send_byte(img[1][23:16], 100);
        send_byte(img[1][31:24], 100);
        send_word(img[2], 100);
        wait_end(cyc);
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || words_loaded_o !== 3 || wa_q.size() != 3) begin
            errors++;
            $display("FAIL start_ignored: got done=%0b n=%0d writes=%0d want 1 3 3",
                     done_o, words_loaded_o, wa_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa_q[i] !== AW'(i) || wd_q[i] !== img[i]) begin
                    errors++;
                    $display("FAIL start_ign_write%0d: got a=%0d d=%h want a=%0d d=%h",
                             i, wa_q[i], wd_q[i], i, img[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_valid();
        test_bad_header();
        test_timeout();
        test_reset_mid();
        test_start_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
